// File: rtl/fc_pkg.sv
// Shared constants and types for the fully-connected layer feeder.
package fc_pkg;

   localparam int DATA_BITS_DEF   = 8;
   localparam int CHANNEL_LEN_DEF = 3;
   localparam int PIXELS_DEF      = 16;
   localparam int IDX_W_DEF       = $clog2(PIXELS_DEF);

   typedef enum logic {
      RD_IDLE   = 1'b0,
      RD_STREAM = 1'b1
   } rd_state_t;

   function automatic int idx_width(input int pixels);
      return (pixels > 1) ? $clog2(pixels) : 1;
   endfunction

endpackage

// File: rtl/fc_frame_bank.sv
// One frame buffer: write port, asynchronous read port and a full flag.
module fc_frame_bank #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             set_full,
   input  logic             free,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // set_full only fires while filling and free only while full, so they never collide
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         full <= 1'b0;
      end else if (set_full) begin
         full <= 1'b1;
      end else if (free) begin
         full <= 1'b0;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fc_feeder.sv
// Ping-pong frame buffer between the pooling stage and the fully-connected layer.
//   state     | meaning
//   RD_IDLE   | waiting for bank rd_bank to become full
//   RD_STREAM | presenting beats of bank rd_bank, one per output transfer
module fc_feeder
   import fc_pkg::*;
#(
   parameter int DATA_BITS   = DATA_BITS_DEF,
   parameter int CHANNEL_LEN = CHANNEL_LEN_DEF,
   parameter int PIXELS      = PIXELS_DEF,
   localparam int W          = CHANNEL_LEN * DATA_BITS,
   localparam int IW         = idx_width(PIXELS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_val,
   output logic          in_ready,
   input  logic [W-1:0]  data_in,
   output logic          out_val,
   input  logic          out_ready,
   output logic [W-1:0]  data_out,
   output logic [IW-1:0] out_index,
   output logic          out_last,
   output logic [7:0]    frame_cnt
);

   rd_state_t     state, state_nxt;
   logic          wr_bank, rd_bank;
   logic [IW-1:0] wr_cnt, rd_cnt;
   logic [IW-1:0] rd_addr;
   logic [1:0]    full;
   logic [W-1:0]  bank_rd_data [2];
   logic [W-1:0]  rd_sel;
   logic          wr_fire, wr_done, out_fire, rd_done;
   logic          load, adv;

   assign in_ready = !rst && !flush && !full[wr_bank];
   assign wr_fire  = in_val && in_ready;
   assign wr_done  = wr_fire && (wr_cnt == IW'(PIXELS - 1));
   assign out_fire = out_val && out_ready;
   assign rd_done  = (state == RD_STREAM) && out_fire && out_last;
   assign rd_addr  = (state == RD_IDLE) ? '0 : rd_cnt + IW'(1);
   assign rd_sel   = bank_rd_data[rd_bank];
   assign out_index = rd_cnt;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fc_frame_bank #(
         .WIDTH (W),
         .DEPTH (PIXELS),
         .AW    (IW)
      ) u_bank (
         .clk      (clk),
         .rst      (rst),
         .clr      (flush),
         .wr_en    (wr_fire && (wr_bank == 1'(b))),
         .wr_addr  (wr_cnt),
         .wr_data  (data_in),
         .set_full (wr_done && (wr_bank == 1'(b))),
         .free     (rd_done && (rd_bank == 1'(b))),
         .rd_addr  (rd_addr),
         .rd_data  (bank_rd_data[b]),
         .full     (full[b])
      );
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      adv       = 1'b0;
      case (state)
         RD_IDLE: begin
            if (full[rd_bank]) begin
               state_nxt = RD_STREAM;
               load      = 1'b1;
            end
         end
         RD_STREAM: begin
            if (out_fire) begin
               if (out_last) begin
                  state_nxt = RD_IDLE;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         default: state_nxt = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RD_IDLE;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         out_val   <= 1'b0;
         out_last  <= 1'b0;
         data_out  <= '0;
         frame_cnt <= '0;
      end else if (flush) begin
         state    <= RD_IDLE;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         wr_cnt   <= '0;
         rd_cnt   <= '0;
         out_val  <= 1'b0;
         out_last <= 1'b0;
      end else begin
         state <= state_nxt;
         if (wr_fire) begin
            wr_cnt <= wr_done ? '0 : wr_cnt + IW'(1);
            if (wr_done) begin
               wr_bank <= ~wr_bank;
            end
         end
         if (load) begin
            out_val  <= 1'b1;
            data_out <= rd_sel;
            rd_cnt   <= '0;
            out_last <= (PIXELS == 1);
         end else if (adv) begin
            data_out <= rd_sel;
            rd_cnt   <= rd_cnt + IW'(1);
            out_last <= ((rd_cnt + IW'(1)) == IW'(PIXELS - 1));
         end else if (rd_done) begin
            // one idle cycle follows every frame before the other bank is picked up
            out_val   <= 1'b0;
            out_last  <= 1'b0;
            rd_cnt    <= '0;
            rd_bank   <= ~rd_bank;
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_fc_feeder.sv
// Directed self-checking bench for fc_feeder with default parameters.
module tb_fc_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_val = 1'b0;
   logic        in_ready;
   logic [23:0] data_in = '0;
   logic        out_val;
   logic        out_ready = 1'b0;
   logic [23:0] data_out;
   logic [3:0]  out_index;
   logic        out_last;
   logic [7:0]  frame_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int pi, po;
   int tag = 0;
   bit const_pay = 1'b0;

   always #5 clk = ~clk;

   fc_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_val    (in_val),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_val   (out_val),
      .out_ready (out_ready),
      .data_out  (data_out),
      .out_index (out_index),
      .out_last  (out_last),
      .frame_cnt (frame_cnt)
   );

   function automatic logic [23:0] pay(input int f, input int k);
      if (const_pay) return 24'h807FFF;
      return {8'(2 * k + tag), 8'(-k), 8'(16 * f + k)};
   endfunction

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_in_ready_low", 32'(in_ready), 32'd0);
      tick();
      check("rst_out_val", 32'(out_val), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_out_index", 32'(out_index), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      rst = 1'b0;
      in_val = 1'b0;
      #1;
      check("rst_in_ready_after", 32'(in_ready), 32'd1);
   endtask

   task automatic fill(input int n);
      for (int i = 0; i < n; i++) begin
         in_val  = 1'b1;
         data_in = pay(pi / 16, pi % 16);
         check("fill_in_ready", 32'(in_ready), 32'd1);
         tick();
         pi++;
      end
      in_val = 1'b0;
   endtask

   // cycle loop: pushes until pi==n_in, checks every output transfer in order,
   // checks holds under backpressure and the out_val gap after each frame
   task automatic stream(input int n_in, input int n_out, input int mode);
      bit          hold, want_hi, in_fire, out_fire;
      logic [23:0] hd;
      logic [3:0]  hi;
      logic        hl;
      int          gap, cyc;
      hold = 1'b0; want_hi = 1'b0; gap = 0; cyc = 0;
      hd = '0; hi = '0; hl = 1'b0;
      while ((pi < n_in || po < n_out || gap != 0) && cyc < 2000) begin
         in_val    = (pi < n_in);
         data_in   = pay(pi / 16, pi % 16);
         out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         #1;
         if (gap == 2) check("gap_out_val_low", 32'(out_val), 32'd0);
         else if (gap == 1) check("gap_next_frame_val", 32'(out_val), 32'd1);
         if (hold) begin
            check("hold_val", 32'(out_val), 32'd1);
            check("hold_data", 32'(data_out), 32'(hd));
            check("hold_index", 32'(out_index), 32'(hi));
            check("hold_last", 32'(out_last), 32'(hl));
         end
         in_fire  = in_val && in_ready;
         out_fire = out_val && out_ready;
         if (out_fire) begin
            check("beat_index", 32'(out_index), 32'(po % 16));
            check("beat_data", 32'(data_out), 32'(pay(po / 16, po % 16)));
            check("beat_last", 32'(out_last), 32'((po % 16) == 15));
            po++;
         end
         hold = out_val && !out_ready;
         hd = data_out; hi = out_index; hl = out_last;
         @(posedge clk);
         #1;
         cyc++;
         if (in_fire) pi++;
         if (gap == 2) gap = want_hi ? 1 : 0;
         else if (gap == 1) gap = 0;
         if (out_fire && (po % 16) == 0) begin
            gap = 2;
            want_hi = (pi >= po + 16);
         end
      end
      in_val = 1'b0;
      check("stream_beats_out", 32'(po), 32'(n_out));
      check("stream_beats_in", 32'(pi), 32'(n_in));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      do_reset();

      // single frame: (k, -k, 2k), two-edge latency, ordered beats
      tag = 0; pi = 0; out_ready = 1'b1;
      fill(16);
      check("lat_one_edge", 32'(out_val), 32'd0);
      tick();
      check("lat_two_edges", 32'(out_val), 32'd1);
      for (int i = 0; i < 16; i++) begin
         check("f1_index", 32'(out_index), 32'(i));
         check("f1_data", 32'(data_out), 32'(pay(0, i)));
         check("f1_last", 32'(out_last), 32'(i == 15));
         tick();
      end
      check("f1_val_after", 32'(out_val), 32'd0);
      check("f1_frame_cnt", 32'(frame_cnt), 32'd1);

      // 48 beats against a stalled consumer, then release
      do_reset();
      tag = 1; pi = 0; po = 0; out_ready = 1'b0;
      fill(32);
      in_val = 1'b1; data_in = pay(2, 0);
      #1;
      check("both_full_in_ready", 32'(in_ready), 32'd0);
      tick(); tick();
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_val", 32'(out_val), 32'd1);
      check("stall_index", 32'(out_index), 32'd0);
      check("stall_data", 32'(data_out), 32'(pay(0, 0)));
      stream(48, 48, 0);
      check("three_frame_cnt", 32'(frame_cnt), 32'd3);

      // flush at output beat 7 with the second bank full
      tag = 2; pi = 0; po = 0; out_ready = 1'b0;
      fill(32);
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check("pre_flush_index", 32'(out_index), 32'd7);
      check("pre_flush_data", 32'(data_out), 32'(pay(0, 7)));
      flush = 1'b1;
      #1;
      check("flush_in_ready_low", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      #1;
      check("flush_out_val", 32'(out_val), 32'd0);
      check("flush_in_ready", 32'(in_ready), 32'd1);
      check("flush_frame_cnt", 32'(frame_cnt), 32'd3);
      tag = 3; pi = 0; po = 0;
      stream(16, 16, 0);
      check("post_flush_frame_cnt", 32'(frame_cnt), 32'd4);

      // toggling out_ready across two frames
      tag = 4; pi = 0; po = 0;
      stream(32, 32, 1);
      check("toggle_frame_cnt", 32'(frame_cnt), 32'd6);

      // reset while beat 9 of a frame is being written
      tag = 5; pi = 0; out_ready = 1'b1;
      fill(9);
      in_val = 1'b1; data_in = pay(0, 9);
      do_reset();
      tag = 6; pi = 0; po = 0;
      stream(16, 16, 0);
      check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

      // extreme signed payload passes unchanged
      const_pay = 1'b1; pi = 0; po = 0;
      stream(16, 16, 0);
      check("const_frame_cnt", 32'(frame_cnt), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fc_feeder.md
FC_FEEDER -- requirements
Module: fc_feeder

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, bits per channel sample.
REQ-002 SHALL have parameter CHANNEL_LEN, default 3, channels per beat.
REQ-003 SHALL have parameter PIXELS, default 16, beats per frame (power of two).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous drop of all buffered and in-flight frames.
REQ-007 in_val  input  1  upstream (pooling) beat valid.
REQ-008 in_ready  output  1  feeder can accept a beat.
REQ-009 data_in  input  CHANNEL_LEN*DATA_BITS  signed packed channel samples; channel 0 in LSBs.
REQ-010 out_val  output  1  beat valid toward the fully-connected layer.
REQ-011 out_ready  input  1  downstream accepts beat (tied high when the consumer has no backpressure).
REQ-012 data_out  output  CHANNEL_LEN*DATA_BITS  beat payload, same packing as data_in.
REQ-013 out_index  output  log2(PIXELS)  beat position within frame.
REQ-014 out_last  output  1  marks beat PIXELS-1.
REQ-015 frame_cnt  output  8  count of fully streamed frames, wraps 255->0.

Function
REQ-016 Input transfer SHALL occur on an edge where in_val && in_ready; output transfer where out_val && out_ready.
REQ-017 Two banks of PIXELS entries SHALL be used ping-pong; writes fill bank wr_bank at address wr_cnt in arrival order.
REQ-018 in_ready SHALL be high iff bank wr_bank is not full and flush is low.
REQ-019 On the PIXELS-th write to a bank, that bank SHALL be marked full, wr_bank toggles, wr_cnt returns to 0.
REQ-020 Read FSM SHALL have states IDLE and STREAM; IDLE->STREAM on the edge where bank rd_bank is full, loading entry 0 into the output registers.
REQ-021 First out_val of a frame SHALL be high in the cycle two edges after the edge of that frame's final input transfer, when the reader is idle.
REQ-022 data_out, out_index, out_last, out_val SHALL be registered and held stable while out_val && !out_ready.
REQ-023 On each output transfer in STREAM, rd_cnt SHALL advance and the next entry SHALL be loaded; out_last SHALL be high only with out_index = PIXELS-1.
REQ-024 On transfer of the out_last beat: bank rd_bank SHALL be cleared to not-full, rd_bank toggles, frame_cnt increments, FSM goes to IDLE, out_val drops for exactly one cycle before a waiting full bank streams.
REQ-025 A bank completing on the same edge another bank is freed SHALL have both events take effect.
REQ-026 With both banks full, in_ready SHALL be low; no beat is dropped or overwritten.
REQ-027 Payload SHALL pass bit-exact; no arithmetic or sign change.
REQ-028 flush high SHALL, on that edge, clear both full flags, wr_cnt, rd_cnt, wr_bank, rd_bank, force IDLE and out_val low; frame_cnt is retained.

Reset
REQ-029 rst SHALL take priority over flush and all transfers.
REQ-030 Reset values: in_ready 0 during rst, 1 the cycle after; out_val 0; data_out 0; out_index 0; out_last 0; frame_cnt 0; FSM IDLE; both banks not-full; wr_bank, rd_bank, wr_cnt, rd_cnt 0.
REQ-031 Bank storage contents SHALL need no reset.

Structure
REQ-032 Package fc_pkg SHALL hold DATA_BITS, CHANNEL_LEN, PIXELS defaults, the index width constant, and the read-FSM state type.
REQ-033 One sub-module fc_frame_bank (PIXELS-entry write-port/read-port buffer with full flag) SHALL be instantiated twice.

Verification
REQ-034 16 beats, channel values (k, -k, 2k) for k=0..15, out_ready=1 -> out_val high two edges after beat 15, 16 consecutive beats identical in order, out_last on index 15, frame_cnt=1.
REQ-035 48 beats continuous in_val, out_ready=0 -> in_ready low after beat 32; release out_ready -> three frames bit-exact, one-cycle out_val gap between frames, frame_cnt=3.
REQ-036 out_ready toggled every cycle during a stream -> each beat held stable until accepted, no duplicate or skipped index.
REQ-037 flush at output beat 7 with second bank full -> next cycle out_val=0, in_ready=1, frame_cnt unchanged; next 16 inputs stream as a fresh frame from index 0.
REQ-038 rst asserted mid-write at beat 9 -> all outputs at reset values next cycle; following 16 inputs form frame 0 correctly.
REQ-039 Payload 0x80_7F_FF per beat -> emitted unchanged.
